// File: rtl/factor_sieve.sv
// factor_sieve: sweeps 0..255 and streams every number whose divisor bitmap
// (bit i = divisible by i+2) equals, or contains, the latched target bitmap.

module residue_ctr #(
  parameter int unsigned K = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic adv,
  output logic zero
);
  logic [4:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (adv) q <= (q == 5'(K - 1)) ? 5'd0 : q + 5'd1;
  end

  assign zero = (q == 5'd0);
endmodule

module factor_sieve (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [17:0] target,
  input  logic        mode,
  input  logic        match_ready,
  output logic        busy,
  output logic        match_valid,
  output logic [7:0]  match_number,
  output logic        done
);
  localparam int NUM_RES = 8;

  function automatic int unsigned res_mod(input int i);
    case (i)
      0:       return 3;
      1:       return 5;
      2:       return 7;
      3:       return 9;
      4:       return 11;
      5:       return 13;
      6:       return 17;
      default: return 19;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  state_t              state, state_nx;
  logic [7:0]          cand;
  logic [17:0]         tgt;
  logic                mode_q;
  logic [NUM_RES-1:0]  rz;
  logic [17:0]         bm;
  logic                hit;
  logic                load, adv, cap, rel;

  // Odd moduli tracked by wrap counters; powers of two come straight from cand.
  genvar g;
  generate
    for (g = 0; g < NUM_RES; g++) begin : g_res
      localparam int unsigned KM = res_mod(g);
      residue_ctr #(.K(KM)) u_res (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .adv   (adv),
        .zero  (rz[g])
      );
    end
  endgenerate

  always_comb begin
    bm      = '0;
    bm[0]   = (cand[0] == 1'b0);
    bm[1]   = rz[0];
    bm[2]   = (cand[1:0] == 2'd0);
    bm[3]   = rz[1];
    bm[5]   = rz[2];
    bm[6]   = (cand[2:0] == 3'd0);
    bm[7]   = rz[3];
    bm[9]   = rz[4];
    bm[11]  = rz[5];
    bm[14]  = (cand[3:0] == 4'd0);
    bm[15]  = rz[6];
    bm[17]  = rz[7];
    // Composite divisors from coprime factor pairs.
    bm[4]   = bm[0] & bm[1];
    bm[8]   = bm[3] & bm[0];
    bm[10]  = bm[2] & bm[1];
    bm[12]  = bm[5] & bm[0];
    bm[13]  = bm[3] & bm[1];
    bm[16]  = bm[7] & bm[0];
  end

  assign hit = mode_q ? ((bm & tgt) == tgt) : (bm == tgt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    cap      = 1'b0;
    rel      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (hit) begin
          cap      = 1'b1;
          state_nx = HOLD;
        end else if (cand == 8'hFF) begin
          state_nx = DONE;
        end else begin
          adv = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (match_ready) begin
          rel = 1'b1;
          if (cand == 8'hFF) begin
            state_nx = DONE;
          end else begin
            adv      = 1'b1;
            state_nx = SCAN;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand         <= '0;
      tgt          <= '0;
      mode_q       <= 1'b0;
      match_valid  <= 1'b0;
      match_number <= '0;
    end else begin
      if (load) begin
        cand   <= '0;
        tgt    <= target;
        mode_q <= mode;
      end else if (adv) begin
        cand <= cand + 8'd1;
      end
      if (cap) begin
        match_valid  <= 1'b1;
        match_number <= cand;
      end else if (rel || (abort && state != IDLE)) begin
        match_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_factor_sieve.sv
// Directed bench for factor_sieve: full sweeps, backpressure, abort, reset and
// start filtering, with hand-computed match lists and done timing.

module tb_factor_sieve;
  logic        clk = 1'b0;
  logic        reset, start, abort, mode, match_ready;
  logic [17:0] target;
  logic        busy, match_valid, done;
  logic [7:0]  match_number;

  int n_cmp = 0;
  int n_bad = 0;
  int got[$];
  int de;

  always #5 clk = ~clk;

  factor_sieve dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .target       (target),
    .mode         (mode),
    .match_ready  (match_ready),
    .busy         (busy),
    .match_valid  (match_valid),
    .match_number (match_number),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int gi(input int i);
    return (i < got.size()) ? got[i] : -1;
  endfunction

  // One sweep with ready normally high. Optional stall at a given match,
  // abort at a given match, and a spurious start at a given edge count.
  // done_edge = edges after the start edge when done is seen; -1 on abort.
  task automatic sweep(input logic [17:0] t, input logic m, input int stall_at,
                       input int stall_len, input int abort_at, input int spur_at,
                       output int done_edge);
    int edges = 0;
    int sc = 0;
    bit trig = 0;
    got.delete();
    done_edge = -2;
    @(negedge clk);
    target = t; mode = m; start = 1'b1; match_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    forever begin
      if (edges == spur_at) begin
        start = 1'b1; target = 18'h00417; mode = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (trig) begin
        chk("hold_vld", match_valid, 1);
        chk("hold_num", match_number, stall_at);
      end
      if (match_valid && match_number == stall_at && sc < stall_len) begin
        trig = 1; sc++; match_ready = 1'b0;
      end else begin
        match_ready = 1'b1;
      end
      if (match_valid && match_number == abort_at) begin
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_vld", match_valid, 0);
        chk("abort_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_done2", done, 0);
        done_edge = -1;
        break;
      end
      if (match_valid && match_ready) begin
        got.push_back(match_number);
        trig = 0;
      end
      if (done) begin
        done_edge = edges;
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("done_once", done, 0);
        break;
      end
      if (edges >= 600) begin
        chk("timeout", 0, 1);
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int exp_t4[8];
    exp_t4 = '{1, 23, 29, 31, 37, 41, 43, 47};
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    target = '0; match_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_vld", match_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_num", match_number, 0);
    @(negedge clk);
    reset = 1'b0;

    // exact 12
    sweep(18'h00417, 1'b0, 999, 0, 999, -1, de);
    chk("t12_cnt", got.size(), 1);
    chk("t12_val", gi(0), 12);
    chk("t12_done", de, 257);

    // superset 19
    sweep(18'h20000, 1'b1, 999, 0, 999, -1, de);
    chk("t19_cnt", got.size(), 14);
    for (int i = 0; i < 14; i++) chk("t19_val", gi(i), 19 * i);
    chk("t19_done", de, 270);

    // exact all-divisors
    sweep(18'h3FFFF, 1'b0, 999, 0, 999, -1, de);
    chk("tall_cnt", got.size(), 1);
    chk("tall_val", gi(0), 0);
    chk("tall_done", de, 257);

    // exact empty bitmap: 1 plus primes 23..251
    sweep(18'h00000, 1'b0, 999, 0, 999, -1, de);
    for (int i = 0; i < 8; i++) chk("tnone_val", gi(i), exp_t4[i]);
    chk("tnone_cnt", got.size(), 47);
    chk("tnone_done", de, 303);

    // backpressure at 3
    sweep(18'h00002, 1'b1, 3, 5, 999, -1, de);
    chk("bp_v0", gi(0), 0);
    chk("bp_v1", gi(1), 3);
    chk("bp_v2", gi(2), 6);
    chk("bp_cnt", got.size(), 86);
    chk("bp_done", de, 347);

    // abort at 38, then restart
    sweep(18'h20000, 1'b1, 999, 0, 38, -1, de);
    chk("ab_flag", de, -1);
    chk("ab_cnt", got.size(), 2);
    sweep(18'h00417, 1'b0, 999, 0, 999, -1, de);
    chk("re_cnt", got.size(), 1);
    chk("re_val", gi(0), 12);
    chk("re_done", de, 257);

    // start while busy must be ignored
    sweep(18'h20000, 1'b1, 999, 0, 999, 5, de);
    chk("sp_cnt", got.size(), 14);
    chk("sp_last", gi(13), 247);
    chk("sp_done", de, 270);

    // async reset mid-SCAN
    @(negedge clk);
    target = 18'h00002; mode = 1'b1; start = 1'b1; match_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_num", match_number, 3);
    chk("pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_vld", match_valid, 0);
    chk("ar_done", done, 0);
    chk("ar_num", match_number, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ar_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
